// File: rtl/cp_remove.sv
// cp_remove
//   Strips the cyclic prefix from a time-synchronised OFDM sample stream.
//   Each symbol slot is CP_LEN prefix samples, which are accepted and
//   dropped, followed by SYM_LEN useful samples, which are forwarded to
//   the FFT stage through a single output register (one-cycle latency).
//   Upstream and downstream use a CYC/STB/ACK handshake.
//
// Optional build macro:
//   CP_REMOVE_SYMCNT_EN  adds the SYM_CNT output, an 8-bit count of
//                        symbols completed in the current frame. The count
//                        is cleared at frame start and saturates at 255.
//
// Ports:
//   CLK_I    in   clock, rising edge
//   RSTN_I   in   synchronous active-low reset
//   DAT_I    in   input sample, [31:16] imag, [15:0] real (2.14)
//   CYC_I    in   upstream frame active
//   STB_I    in   upstream sample valid
//   ACK_O    out  input sample accepted this cycle
//   DAT_O    out  CP-stripped sample
//   CYC_O    out  downstream frame active
//   STB_O    out  DAT_O valid
//   WE_O     out  write strobe (mirrors STB_O)
//   ACK_I    in   downstream accepted DAT_O
//   SYM_CNT  out  symbols completed (CP_REMOVE_SYMCNT_EN only)
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | no frame; waiting for a rising edge on CYC_I
// CP      | discarding cyclic-prefix samples of the current symbol
// DATA    | forwarding useful samples of the current symbol

module cp_remove #(
  parameter int WIDTH   = 32,
  parameter int CP_LEN  = 16,
  parameter int SYM_LEN = 64
) (
  input  logic             CLK_I,
  input  logic             RSTN_I,
  input  logic [WIDTH-1:0] DAT_I,
  input  logic             CYC_I,
  input  logic             STB_I,
  output logic             ACK_O,
  output logic [WIDTH-1:0] DAT_O,
  output logic             CYC_O,
  output logic             STB_O,
  output logic             WE_O,
  input  logic             ACK_I
`ifdef CP_REMOVE_SYMCNT_EN
  ,
  output logic [7:0]       SYM_CNT
`endif
);

  localparam int MAX_LEN = (CP_LEN > SYM_LEN) ? CP_LEN : SYM_LEN;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CNT_W-1:0] CP_LAST   = CNT_W'(CP_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(SYM_LEN - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CP   = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] smp_cnt;
  logic             cyc_q;
  logic             stb_q;
  logic             cyc_o_q;
  logic [WIDTH-1:0] dat_q;

  logic             cyc_rise;
  logic             ack_w;
  logic             xfer_in;
  logic             xfer_out;
  logic             load;
  logic             stb_nxt;

  always_comb begin
    cyc_rise = CYC_I & ~cyc_q;
    ack_w    = 1'b0;
    // Gated by reset so upstream never sees an acceptance that reset discards.
    // In DATA a sample is only taken if the output register is free or
    // being emptied this same cycle.
    if (RSTN_I && CYC_I && STB_I && (state != ST_IDLE))
      ack_w = (state == ST_CP) | ~stb_q | ACK_I;
    xfer_in  = CYC_I & STB_I & ack_w;
    xfer_out = stb_q & ACK_I;
    load     = xfer_in & (state == ST_DATA);
    stb_nxt  = load | (stb_q & ~ACK_I);
  end

  always_ff @(posedge CLK_I) begin
    if (!RSTN_I) begin
      state   <= ST_IDLE;
      smp_cnt <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      cyc_o_q <= 1'b0;
      dat_q   <= '0;
    end else begin
      cyc_q <= CYC_I;
      stb_q <= stb_nxt;
      if (load)
        dat_q <= DAT_I;

      // Downstream frame stays open until the last pending sample is gone.
      if (load)
        cyc_o_q <= 1'b1;
      else if (!CYC_I && !stb_nxt)
        cyc_o_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cyc_rise) begin
            state   <= ST_CP;
            smp_cnt <= '0;
          end
        end
        ST_CP: begin
          if (!CYC_I) begin
            state   <= ST_IDLE;
            smp_cnt <= '0;
          end else if (xfer_in) begin
            if (smp_cnt == CP_LAST) begin
              state   <= ST_DATA;
              smp_cnt <= '0;
            end else begin
              smp_cnt <= smp_cnt + CNT_W'(1);
            end
          end
        end
        ST_DATA: begin
          if (!CYC_I) begin
            state   <= ST_IDLE;
            smp_cnt <= '0;
          end else if (xfer_in) begin
            if (smp_cnt == DATA_LAST) begin
              state   <= ST_CP;
              smp_cnt <= '0;
            end else begin
              smp_cnt <= smp_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          smp_cnt <= '0;
        end
      endcase
    end
  end

`ifdef CP_REMOVE_SYMCNT_EN
  logic [7:0] sym_cnt_q;
  logic       sym_done;

  assign sym_done = load & (smp_cnt == DATA_LAST);

  // Held after the frame ends so the final count stays readable; cleared
  // only when the next frame begins.
  always_ff @(posedge CLK_I) begin
    if (!RSTN_I)
      sym_cnt_q <= '0;
    else if ((state == ST_IDLE) && cyc_rise)
      sym_cnt_q <= '0;
    else if (sym_done && (sym_cnt_q != 8'hff))
      sym_cnt_q <= sym_cnt_q + 8'd1;
  end

  assign SYM_CNT = sym_cnt_q;
`endif

  assign ACK_O = ack_w;
  assign DAT_O = dat_q;
  assign STB_O = stb_q;
  assign WE_O  = stb_q;
  assign CYC_O = cyc_o_q;

endmodule

// File: tb/tb_cp_remove.sv
module tb_cp_remove;

  localparam int WIDTH   = 32;
  localparam int CP_LEN  = 16;
  localparam int SYM_LEN = 64;
  localparam int SLOT    = CP_LEN + SYM_LEN;

  logic             CLK_I = 1'b0;
  logic             RSTN_I;
  logic [WIDTH-1:0] DAT_I;
  logic             CYC_I;
  logic             STB_I;
  logic             ACK_O;
  logic [WIDTH-1:0] DAT_O;
  logic             CYC_O;
  logic             STB_O;
  logic             WE_O;
  logic             ACK_I;
`ifdef CP_REMOVE_SYMCNT_EN
  logic [7:0]       SYM_CNT;
`endif

  cp_remove #(.WIDTH(WIDTH), .CP_LEN(CP_LEN), .SYM_LEN(SYM_LEN)) dut (
    .CLK_I  (CLK_I),
    .RSTN_I (RSTN_I),
    .DAT_I  (DAT_I),
    .CYC_I  (CYC_I),
    .STB_I  (STB_I),
    .ACK_O  (ACK_O),
    .DAT_O  (DAT_O),
    .CYC_O  (CYC_O),
    .STB_O  (STB_O),
    .WE_O   (WE_O),
    .ACK_I  (ACK_I)
`ifdef CP_REMOVE_SYMCNT_EN
    ,
    .SYM_CNT(SYM_CNT)
`endif
  );

  always #5 CLK_I = ~CLK_I;

  int tests   = 0;
  int fails   = 0;
  int out_cnt = 0;
  logic [WIDTH-1:0] q[$];

  bit ack_slow      = 1'b0;
  bit ack_force_low = 1'b0;
  int ack_phase     = 0;

  logic             hold_pend = 1'b0;
  logic [WIDTH-1:0] hold_dat  = '0;

  // Downstream ready pattern: always, 1-in-3, or forced low.
  initial begin
    ACK_I = 1'b1;
    forever begin
      @(posedge CLK_I);
      #2;
      ack_phase = (ack_phase + 1) % 3;
      if (ack_force_low)
        ACK_I = 1'b0;
      else if (ack_slow)
        ACK_I = (ack_phase == 0);
      else
        ACK_I = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every transfer out and checks that a
  // stalled output holds its value.
  always @(negedge CLK_I) begin
    logic [WIDTH-1:0] exp_v;
    if (RSTN_I) begin
      tests++;
      if (WE_O !== STB_O) begin
        fails++;
        $display("FAIL we_eq_stb: WE_O=%0b STB_O=%0b", WE_O, STB_O);
      end
      if (STB_O) begin
        tests++;
        if (CYC_O !== 1'b1) begin
          fails++;
          $display("FAIL cyc_o_with_stb: CYC_O=%0b required 1", CYC_O);
        end
      end
      if (hold_pend) begin
        tests++;
        if (STB_O !== 1'b1 || DAT_O !== hold_dat) begin
          fails++;
          $display("FAIL stall_hold: STB_O=%0b DAT_O=%0d required STB_O=1 DAT_O=%0d",
                   STB_O, DAT_O, hold_dat);
        end
      end
      if (STB_O && ACK_I) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_out: DAT_O=%0d with empty scoreboard", DAT_O);
        end else begin
          exp_v = q.pop_front();
          out_cnt++;
          if (DAT_O !== exp_v) begin
            fails++;
            $display("FAIL out_data: DAT_O=%0d required %0d", DAT_O, exp_v);
          end
        end
      end
      hold_pend = STB_O && !ACK_I;
      hold_dat  = DAT_O;
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Offer one sample until accepted, checking ACK_O each cycle against
  // the expected phase: IDLE on the frame's first cycle, CP, or DATA.
  task automatic send(input logic [WIDTH-1:0] v, input bit first, input bit in_cp);
    bit done;
    bit exp_ack;
    done  = 1'b0;
    DAT_I = v;
    STB_I = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge CLK_I);
      if (first && n == 0)
        exp_ack = 1'b0;
      else if (in_cp)
        exp_ack = 1'b1;
      else
        exp_ack = (q.size() == 0) || ACK_I;
      tests++;
      if (ACK_O !== exp_ack) begin
        fails++;
        $display("FAIL ack_o: sample %0d got %0b required %0b", v, ACK_O, exp_ack);
      end
      done = ACK_O;
      @(posedge CLK_I);
      #1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: sample %0d never accepted", v);
    end
  endtask

  // Drive a ramp frame; CYC_I is left high for the caller to drop.
  task automatic run_frame(input int n, input int release_at);
    CYC_I = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (k == release_at)
        ack_force_low = 1'b0;
      send(WIDTH'(k), k == 0, (k % SLOT) < CP_LEN);
      if ((k % SLOT) >= CP_LEN)
        q.push_back(WIDTH'(k));
    end
  endtask

  task automatic check_symcnt(input int exp);
    @(negedge CLK_I);
`ifdef CP_REMOVE_SYMCNT_EN
    chk("sym_cnt", WIDTH'(SYM_CNT), WIDTH'(exp));
`endif
    @(posedge CLK_I);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || STB_O) && n < 100) begin
      @(posedge CLK_I);
      #1;
      n++;
    end
    @(negedge CLK_I);
    chk("drain_q_empty", WIDTH'(q.size()), '0);
    chk("drain_stb_o", WIDTH'(STB_O), '0);
    @(posedge CLK_I);
    #1;
  endtask

  task automatic check_out_cnt(input string name, input int exp);
    chk(name, WIDTH'(out_cnt), WIDTH'(exp));
    out_cnt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTN_I = 1'b0;
    CYC_I  = 1'b0;
    STB_I  = 1'b0;
    DAT_I  = '0;
    repeat (2) @(posedge CLK_I);
    @(negedge CLK_I);
    chk("rst_stb_o", WIDTH'(STB_O), '0);
    chk("rst_cyc_o", WIDTH'(CYC_O), '0);
    chk("rst_we_o",  WIDTH'(WE_O),  '0);
    chk("rst_ack_o", WIDTH'(ACK_O), '0);
    chk("rst_dat_o", DAT_O, '0);
`ifdef CP_REMOVE_SYMCNT_EN
    chk("rst_sym_cnt", WIDTH'(SYM_CNT), '0);
`endif
    @(posedge CLK_I);
    #1;
    RSTN_I = 1'b1;
    @(posedge CLK_I);
    #1;

    // 160-sample ramp, downstream always ready: 16..79, 96..159.
    out_cnt = 0;
    run_frame(160, -1);
    CYC_I = 1'b0;
    STB_I = 1'b0;
    check_symcnt(2);
    drain();
    check_out_cnt("full_frame_count", 128);

    // Same frame, downstream ready 1 cycle in 3.
    ack_slow = 1'b1;
    run_frame(160, -1);
    CYC_I = 1'b0;
    STB_I = 1'b0;
    check_symcnt(2);
    drain();
    check_out_cnt("stall_frame_count", 128);
    ack_slow = 1'b0;

    // Frame abandoned after sample 40: only 16..40 come out.
    run_frame(41, -1);
    CYC_I = 1'b0;
    STB_I = 1'b0;
    @(posedge CLK_I);
    #1;
    @(negedge CLK_I);
    chk("abort_cyc_o", WIDTH'(CYC_O), '0);
    chk("abort_stb_o", WIDTH'(STB_O), '0);
    @(posedge CLK_I);
    #1;
    check_out_cnt("abort_count", 25);
    CYC_I = 1'b1;
    STB_I = 1'b1;
    DAT_I = '0;
    @(negedge CLK_I);
    chk("abort_idle_ack", WIDTH'(ACK_O), '0);
    @(posedge CLK_I);
    #1;
    CYC_I = 1'b0;
    STB_I = 1'b0;
    repeat (2) @(posedge CLK_I);
    #1;
    drain();

    // One-cycle reset while sample 49 is pending at the output.
    out_cnt = 0;
    run_frame(50, -1);
    RSTN_I = 1'b0;
    STB_I  = 1'b1;
    DAT_I  = WIDTH'(50);
    @(negedge CLK_I);
    chk("pre_rst_stb_o", WIDTH'(STB_O), 1);
    chk("pre_rst_dat_o", DAT_O, WIDTH'(49));
    @(posedge CLK_I);
    #1;
    RSTN_I = 1'b1;
    CYC_I  = 1'b0;
    STB_I  = 1'b0;
    q.delete();
    @(negedge CLK_I);
    chk("mid_rst_stb_o", WIDTH'(STB_O), '0);
    chk("mid_rst_cyc_o", WIDTH'(CYC_O), '0);
    chk("mid_rst_we_o",  WIDTH'(WE_O),  '0);
    chk("mid_rst_ack_o", WIDTH'(ACK_O), '0);
    chk("mid_rst_dat_o", DAT_O, '0);
`ifdef CP_REMOVE_SYMCNT_EN
    chk("mid_rst_sym_cnt", WIDTH'(SYM_CNT), '0);
`endif
    @(posedge CLK_I);
    #1;
    check_out_cnt("pre_rst_count", 33);
    run_frame(80, -1);
    CYC_I = 1'b0;
    STB_I = 1'b0;
    check_symcnt(1);
    drain();
    check_out_cnt("post_rst_count", 64);

    // Back-to-back 80-sample frames with sample 79 held across the gap.
    run_frame(80, -1);
    CYC_I         = 1'b0;
    STB_I         = 1'b0;
    ack_force_low = 1'b1;
    check_symcnt(1);
    run_frame(80, 3);
    CYC_I = 1'b0;
    STB_I = 1'b0;
    check_symcnt(1);
    drain();
    check_out_cnt("b2b_count", 128);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cp_remove.md
CP_REMOVE -- requirements
Module: cp_remove

Interface
REQ-001 Parameter WIDTH, default 32, sample width: [31:16] imaginary, [15:0] real, format 2.14.
REQ-002 Parameter CP_LEN, default 16, cyclic-prefix samples discarded per OFDM symbol.
REQ-003 Parameter SYM_LEN, default 64, useful samples forwarded per OFDM symbol.
REQ-004 CLK_I  in  1  single clock; all logic on rising edge.
REQ-005 RSTN_I  in  1  reset, synchronous, active-low.
REQ-006 DAT_I  in  WIDTH  time-synchronised sample from the synchroniser stage.
REQ-007 CYC_I  in  1  upstream frame active.
REQ-008 STB_I  in  1  upstream sample valid.
REQ-009 ACK_O  out  1  sample accepted this cycle.
REQ-010 DAT_O  out  WIDTH  CP-stripped sample to FFT stage.
REQ-011 CYC_O  out  1  downstream frame active.
REQ-012 STB_O  out  1  DAT_O valid.
REQ-013 WE_O  out  1  write strobe, equal to STB_O.
REQ-014 ACK_I  in  1  downstream accepted DAT_O.
REQ-015 SYM_CNT  out  8  symbols completed in current frame (only with CP_REMOVE_SYMCNT_EN).

Function
REQ-016 Transfer in = CYC_I & STB_I & ACK_O; transfer out = STB_O & ACK_I.
REQ-017 FSM states IDLE, CP, DATA; sample counter smp_cnt, width clog2(max(CP_LEN,SYM_LEN)).
REQ-018 IDLE -> CP on rising edge of CYC_I (CYC_I=1, registered CYC_I=0), smp_cnt cleared same cycle.
REQ-019 CP: each transfer in is discarded, smp_cnt increments; on the CP_LEN-th transfer -> DATA, smp_cnt=0.
REQ-020 DATA: each transfer in loads DAT_I into the output register, STB_O=1 next cycle; on the SYM_LEN-th transfer -> CP, smp_cnt=0, symbol counter +1.
REQ-021 Forward latency exactly one cycle from transfer in to STB_O high.
REQ-022 ACK_O = CYC_I & STB_I & (state==CP | STB_O==0 | ACK_I) while state!=IDLE; 0 in IDLE.
REQ-023 STB_O and DAT_O hold stable until transfer out; simultaneous transfer out and transfer in reloads register, STB_O stays 1, no bubble.
REQ-024 Transfer out without transfer in clears STB_O next cycle.
REQ-025 CYC_O set on first DATA load of a frame; cleared when CYC_I=0 and STB_O=0.
REQ-026 CYC_I falling mid-symbol: FSM -> IDLE, counters cleared, partial symbol abandoned; a pending output sample is still delivered before CYC_O drops.
REQ-027 CYC_I rising while STB_O=1 (back-to-back frames): pending sample kept; new frame starts in CP.
REQ-028 No sample duplicated or lost under any ACK_I stall pattern.

Reset
REQ-029 RSTN_I=0 on a clock edge: state=IDLE, smp_cnt=0, symbol counter=0, STB_O=0, CYC_O=0, WE_O=0, ACK_O=0, DAT_O=0, registered CYC_I=0.
REQ-030 Reset asserted mid-symbol overrides all transfers that cycle; pending output discarded.

Configuration
REQ-031 Macro CP_REMOVE_SYMCNT_EN defined: SYM_CNT port present, 8-bit symbol counter, cleared on frame start, saturates at 255.
REQ-032 Macro undefined: SYM_CNT port and counter absent; all other behaviour identical.

Verification
REQ-033 One frame, 160 samples ramp 0..159, ACK_I=1 -> DAT_O sequence 16..79, 96..159; 128 outputs; SYM_CNT=2.
REQ-034 Same frame, ACK_I toggling 1-in-3 -> identical output sequence, STB_O/DAT_O stable during stalls, ACK_O low while stalled in DATA, high in CP.
REQ-035 CYC_I dropped after sample 40 -> outputs 16..40 only, CYC_O falls after last acknowledged output, state IDLE.
REQ-036 RSTN_I=0 for 1 cycle at sample 50 with STB_O=1 -> all outputs at reset values next cycle; next frame starts cleanly in CP.
REQ-037 Two frames back-to-back (CYC_I low 1 cycle) of 80 samples each -> outputs 16..79 twice, SYM_CNT=1 after each frame.
REQ-038 Build without CP_REMOVE_SYMCNT_EN -> REQ-033 sequence unchanged, no SYM_CNT port.
